instruction_receiver: RTL
=========================

# instruction_receiver

Parametrised serial instruction receiver: assembles a WIDTH-bit instruction one bit at a time from a data switch (`data_bit`) qualified by a confirm button (`confirm_bit`), MSB first. Adds input synchronisation, a confirm-release guard, an inactivity timeout, a consumer acknowledge handshake and a synchronous restart. Sits between the board switches/buttons and the servo command decoder, which consumes `instruction` when `instruction_ready` is high.

## Interface
- `WIDTH`, 10: instruction length in bits, at least 2.
- `GUARD_CYCLES`, 10: consecutive low samples of synchronised confirm needed before the next bit is accepted, at least 1.
- `TIMEOUT_CYCLES`, 0: WAIT-state cycles allowed between bits of a partial word; 0 disables the timeout.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `data_bit`  in  1  serial data level, asynchronous to `clk`.
- `confirm_bit`  in  1  confirm button, asynchronous; high latches the current `data_bit`.
- `restart`  in  1  synchronous; discards any partial or ready word.
- `instruction_ack`  in  1  consumer has taken `instruction`; valid only in READY.
- `waiting_bit`  out  1  high in WAIT, meaning ready for the next bit.
- `bit_count`  out  $clog2(WIDTH+1)  number of bits captured in the current word.
- `instruction_ready`  out  1  high in READY.
- `instruction`  out  WIDTH  last completed word; holds until the next word completes.
- `frame_error`  out  1  one-cycle pulse when a partial word times out.

## Operation
- `data_bit` and `confirm_bit` each pass through a two-flop synchroniser, giving `d_s` and `c_s`. All logic below uses only `d_s` and `c_s`.
- Shift register: `sr <= {sr[WIDTH-2:0], d_s}`. The first bit captured ends in the MSB.
- GUARD state
  - Guard counter increments on each `c_s==0` cycle.
  - Any `c_s==1` cycle clears the counter.
  - On the GUARD_CYCLES-th consecutive low sample: if `bit_count==WIDTH`, then `instruction<=sr` and go to READY; otherwise go to WAIT.
- WAIT state (`waiting_bit=1`)
  - On `c_s==1`: shift in `d_s`, increment `bit_count`, clear the guard counter, go to GUARD.
  - Timeout counter increments on each cycle with `bit_count>0`.
  - When the timeout counter reaches TIMEOUT_CYCLES (if TIMEOUT_CYCLES≠0): clear `sr` and `bit_count`, pulse `frame_error`, stay in WAIT.
  - The timeout counter clears on any capture or state exit.
- READY state (`instruction_ready=1`)
  - Confirm activity is ignored.
  - On `instruction_ack`: clear `sr` and `bit_count`, clear the guard counter, go to GUARD. The next word therefore needs the button released first.
- `restart` has priority over `instruction_ack` and over all state actions. From any state it clears `sr`, `bit_count` and both counters, and goes to GUARD. `instruction` is unchanged.
- `instruction_ack` outside READY is ignored.
- A capture in WAIT and a timeout expiry on the same cycle: the capture wins and no `frame_error` is raised.
- Counter widths are sized to hold GUARD_CYCLES and TIMEOUT_CYCLES without wrap. `bit_count` never exceeds WIDTH.
- Reset (async assert, sync release)
  - State goes to GUARD; all counters, `sr` and synchroniser flops go to 0.
  - Outputs: `waiting_bit=0`, `bit_count=0`, `instruction_ready=0`, `instruction=0`, `frame_error=0`.
  - First `waiting_bit=1` appears GUARD_CYCLES+1 cycles after reset release, provided confirm is held low (the +1 covers the state-register update).

## Timing
- Capture latency: `confirm_bit` high sampled at edge N, `c_s` high after edge N+1, capture at edge N+2. After edge N+2, `waiting_bit` is 0 and `bit_count` is incremented.
- Release guard: WAIT is re-entered at the edge that sees the GUARD_CYCLES-th consecutive `c_s==0`. `waiting_bit` rises after that edge.
- Completion: the WIDTH-th capture, then the guard completes. `instruction` and `instruction_ready` update on the same edge.
- `instruction_ack` high at edge M while in READY: `instruction_ready` low after edge M.
- `frame_error` is exactly one cycle wide.
- All outputs are registered.

## Test plan
Bench parameters: WIDTH=10, GUARD_CYCLES=4, TIMEOUT_CYCLES=100.
- Reset and guard: release reset with confirm low → `waiting_bit` rises 5 cycles later; all other outputs 0.
- Full word: enter bits 1,0,1,1,0,0,1,1,1,0, each with confirm held 3 cycles then low ≥6 cycles → `instruction=10'h2CE`, `instruction_ready=1`, `bit_count=10`. Ack → ready low, `bit_count=0`, `waiting_bit` high 4 cycles after GUARD entry.
- Bounce: toggle confirm 1,0,1,0 on alternate cycles for one bit → exactly one bit captured; `bit_count` increments by 1.
- Timeout: capture 3 bits, then idle 100 cycles in WAIT → single-cycle `frame_error`, `bit_count=0`, `instruction` unchanged.
- Restart mid-word and in READY: restart after 5 bits → `bit_count=0`. Restart while ready → ready drops, `instruction` retains its value. Restart and ack in the same cycle → restart behaviour.
- Async reset mid-word: assert reset between clock edges → outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_receiver.sv
// Serial instruction receiver: MSB-first bit capture from a switch/button pair
// with synchronisers, release guard, inactivity timeout and ack handshake.
module instruction_receiver #(
    parameter int WIDTH          = 10,
    parameter int GUARD_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       data_bit,
    input  logic                       confirm_bit,
    input  logic                       restart,
    input  logic                       instruction_ack,
    output logic                       waiting_bit,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       instruction_ready,
    output logic [WIDTH-1:0]           instruction,
    output logic                       frame_error
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int TL = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [BW-1:0] FULL   = BW'(WIDTH);
    localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TL);

    typedef enum logic [1:0] {
        S_GUARD,
        S_WAIT,
        S_READY
    } state_t;

    state_t          state_q;
    logic            rel_q;
    logic            d_s1_q, d_s_q;
    logic            c_s1_q, c_s_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [BW-1:0]   bcnt_q;
    logic [GW-1:0]   gcnt_q;
    logic [TW-1:0]   tcnt_q;
    logic [WIDTH-1:0] instr_q;
    logic            wait_q, rdy_q, ferr_q;

    assign sr_d = {sr_q[WIDTH-2:0], d_s_q};

    // rel_q holds the core in reset for one extra edge after reset drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_GUARD;
            rel_q   <= 1'b1;
            d_s1_q  <= 1'b0;
            d_s_q   <= 1'b0;
            c_s1_q  <= 1'b0;
            c_s_q   <= 1'b0;
            sr_q    <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            tcnt_q  <= '0;
            instr_q <= '0;
            wait_q  <= 1'b0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rel_q  <= 1'b0;
            ferr_q <= 1'b0;
            d_s1_q <= data_bit;
            d_s_q  <= d_s1_q;
            c_s1_q <= confirm_bit;
            c_s_q  <= c_s1_q;
            if (rel_q) begin
                state_q <= S_GUARD;
            end else if (restart) begin
                state_q <= S_GUARD;
                sr_q    <= '0;
                bcnt_q  <= '0;
                gcnt_q  <= '0;
                tcnt_q  <= '0;
                wait_q  <= 1'b0;
                rdy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_GUARD: begin
                        tcnt_q <= '0;
                        if (c_s_q) begin
                            gcnt_q <= '0;
                        end else if (gcnt_q == G_LAST) begin
                            gcnt_q <= '0;
                            if (bcnt_q == FULL) begin
                                instr_q <= sr_q;
                                state_q <= S_READY;
                                rdy_q   <= 1'b1;
                            end else begin
                                state_q <= S_WAIT;
                                wait_q  <= 1'b1;
                            end
                        end else begin
                            gcnt_q <= gcnt_q + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        // a capture beats a timeout landing on the same edge
                        if (c_s_q) begin
                            sr_q    <= sr_d;
                            bcnt_q  <= bcnt_q + 1'b1;
                            gcnt_q  <= '0;
                            tcnt_q  <= '0;
                            state_q <= S_GUARD;
                            wait_q  <= 1'b0;
                        end else if (TIMEOUT_CYCLES != 0 && bcnt_q != '0) begin
                            if (tcnt_q == T_LAST) begin
                                sr_q   <= '0;
                                bcnt_q <= '0;
                                tcnt_q <= '0;
                                ferr_q <= 1'b1;
                            end else begin
                                tcnt_q <= tcnt_q + 1'b1;
                            end
                        end
                    end
                    S_READY: begin
                        if (instruction_ack) begin
                            sr_q    <= '0;
                            bcnt_q  <= '0;
                            gcnt_q  <= '0;
                            state_q <= S_GUARD;
                            rdy_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_GUARD;
                    end
                endcase
            end
        end
    end

    assign waiting_bit       = wait_q;
    assign bit_count         = bcnt_q;
    assign instruction_ready = rdy_q;
    assign instruction       = instr_q;
    assign frame_error       = ferr_q;

endmodule
